// File: rtl/pwm_ctrl_pkg.sv
// Shared encodings for the PWM gating sequencer: state codes, fault-flag bit
// positions and the saturated retry view presented on the status port.
package pwm_ctrl_pkg;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_PFC_SS    = 3'd1,
        ST_INV1_ON   = 3'd2,
        ST_RUN       = 3'd3,
        ST_FAULT     = 3'd4,
        ST_RETRY_RST = 3'd5,
        ST_LOCKOUT   = 3'd6
    } state_t;

    // Bit positions inside Fault_Src and the internal filtered-fault vector
    localparam int FS_BUS_OVP  = 0;
    localparam int FS_IP_OCP   = 1;
    localparam int FS_INV_OCP1 = 2;
    localparam int FS_OP_OVP1  = 3;
    localparam int FS_INV_OCP2 = 4;
    localparam int FS_OP_OVP2  = 5;
    localparam int NUM_FLAGS   = 6;

    // The internal try counter runs one past MAX_RETRY; the port only has 2 bits.
    function automatic logic [1:0] retry_view(input int unsigned v);
        return (v > 3) ? 2'd3 : v[1:0];
    endfunction

endpackage

// File: rtl/fault_filter.sv
// One protection flag: 2-FF synchronizer into a consecutive-low counter.
// fault sets after FILT_CYC synchronized lows and drops on the first high.
module fault_filter #(
    parameter int FILT_CYC = 8
) (
    input  logic clk,
    input  logic rst,
    input  logic flag,
    output logic fault
);

    localparam int CW = (FILT_CYC > 1) ? $clog2(FILT_CYC) : 1;
    localparam logic [CW-1:0] LAST = CW'(FILT_CYC - 1);

    logic          s1, s2;
    logic [CW-1:0] cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1    <= 1'b1;
            s2    <= 1'b1;
            cnt   <= '0;
            fault <= 1'b0;
        end else begin
            s1 <= flag;
            s2 <= s1;
            if (s2) begin
                cnt   <= '0;
                fault <= 1'b0;
            end else if (cnt == LAST) begin
                fault <= 1'b1;
            end else begin
                cnt <= cnt + CW'(1);
            end
        end
    end

endmodule

// File: rtl/pwm_fault_sequencer.sv
// Start-up / fault-recovery sequencer for the PWM gating path:
// PFC soft-start, then INV1, then INV2; retry with latch-clear pulse, then lockout.
module pwm_fault_sequencer
    import pwm_ctrl_pkg::*;
#(
    parameter int FILT_CYC       = 8,
    parameter int PFC_SS_CYC     = 50000,
    parameter int INV_DLY_CYC    = 25000,
    parameter int RETRY_WAIT_CYC = 500000,
    parameter int RST_PULSE_CYC  = 16,
    parameter int MAX_RETRY      = 3,
    parameter int TW             = 20
) (
    input  logic       CLK_50M,
    input  logic       Rst,
    input  logic       Start,
    input  logic       Stop,
    input  logic       Clr_Lock,
    input  logic       BusOvp,
    input  logic       IP_Ocp,
    input  logic       InvOcp1,
    input  logic       OP_Ovp1,
    input  logic       InvOcp2,
    input  logic       OP_Ovp2,
    output logic       PFC_Run,
    output logic       INV1_Run,
    output logic       INV2_Run,
    output logic       Reset_D,
    output logic       Lockout,
    output logic [2:0] State_Code,
    output logic [1:0] Retry_Cnt,
    output logic [5:0] Fault_Src
);

    localparam logic [TW-1:0] PFC_LAST   = TW'(PFC_SS_CYC - 1);
    localparam logic [TW-1:0] INV_LAST   = TW'(INV_DLY_CYC - 1);
    localparam logic [TW-1:0] WAIT_LAST  = TW'(RETRY_WAIT_CYC - 1);
    localparam logic [TW-1:0] PULSE_LAST = TW'(RST_PULSE_CYC - 1);
    localparam int            RCW        = $clog2(MAX_RETRY + 2);
    localparam logic [RCW-1:0] TRY_MAX   = RCW'(MAX_RETRY);
    localparam logic [RCW-1:0] TRY_CAP   = RCW'(MAX_RETRY + 1);

    logic [NUM_FLAGS-1:0] flag_n, f;
    logic                 any_f;

    assign flag_n[FS_BUS_OVP]  = BusOvp;
    assign flag_n[FS_IP_OCP]   = IP_Ocp;
    assign flag_n[FS_INV_OCP1] = InvOcp1;
    assign flag_n[FS_OP_OVP1]  = OP_Ovp1;
    assign flag_n[FS_INV_OCP2] = InvOcp2;
    assign flag_n[FS_OP_OVP2]  = OP_Ovp2;
    assign any_f               = |f;

    for (genvar i = 0; i < NUM_FLAGS; i++) begin : g_filt
        fault_filter #(.FILT_CYC(FILT_CYC)) u_filt (
            .clk  (CLK_50M),
            .rst  (Rst),
            .flag (flag_n[i]),
            .fault(f[i])
        );
    end

    state_t           state, nxt;
    logic [TW-1:0]    tmr;
    logic [RCW-1:0]   tries, tries_d;
    logic [5:0]       src_d;
    logic             enter, tmr_sat;

    assign enter      = (nxt != state);
    assign tmr_sat    = (state == ST_RUN) && (tmr == WAIT_LAST);
    assign State_Code = state;

    always_comb begin
        nxt = state;
        case (state)
            ST_IDLE:
                if (Start && !Stop && !any_f) nxt = ST_PFC_SS;
            ST_PFC_SS:
                if (any_f)                   nxt = ST_FAULT;
                else if (Stop || !Start)     nxt = ST_IDLE;
                else if (tmr == PFC_LAST)    nxt = ST_INV1_ON;
            ST_INV1_ON:
                if (any_f)                   nxt = ST_FAULT;
                else if (Stop || !Start)     nxt = ST_IDLE;
                else if (tmr == INV_LAST)    nxt = ST_RUN;
            ST_RUN:
                if (any_f)                   nxt = ST_FAULT;
                else if (Stop || !Start)     nxt = ST_IDLE;
            ST_FAULT:
                // An exhausted retry budget locks out even if Stop is asserted.
                if (tries > TRY_MAX)         nxt = ST_LOCKOUT;
                else if (Stop)               nxt = ST_IDLE;
                else if (tmr == WAIT_LAST)   nxt = ST_RETRY_RST;
            ST_RETRY_RST:
                if (tmr == PULSE_LAST)       nxt = any_f ? ST_FAULT : ST_PFC_SS;
            ST_LOCKOUT:
                if (Clr_Lock && !Start)      nxt = ST_IDLE;
            default:                         nxt = ST_IDLE;
        endcase
    end

    always_comb begin
        tries_d = tries;
        src_d   = Fault_Src;
        if (enter && nxt == ST_IDLE) begin
            tries_d = '0;
            src_d   = '0;
        end else if (enter && nxt == ST_FAULT) begin
            src_d = f;
            if (tries != TRY_CAP) tries_d = tries + RCW'(1);
        end else if (tmr_sat) begin
            tries_d = '0;
        end
    end

    always_ff @(posedge CLK_50M or posedge Rst) begin
        if (Rst) begin
            state     <= ST_IDLE;
            tmr       <= '0;
            tries     <= '0;
            Retry_Cnt <= '0;
            Fault_Src <= '0;
            PFC_Run   <= 1'b0;
            INV1_Run  <= 1'b0;
            INV2_Run  <= 1'b0;
            Reset_D   <= 1'b0;
            Lockout   <= 1'b0;
        end else begin
            state     <= nxt;
            tmr       <= enter ? '0 : (tmr_sat ? tmr : tmr + TW'(1));
            tries     <= tries_d;
            Retry_Cnt <= retry_view(int'(tries_d));
            Fault_Src <= src_d;
            PFC_Run   <= (nxt == ST_PFC_SS) || (nxt == ST_INV1_ON) || (nxt == ST_RUN);
            INV1_Run  <= (nxt == ST_INV1_ON) || (nxt == ST_RUN);
            INV2_Run  <= (nxt == ST_RUN);
            Reset_D   <= (nxt == ST_RETRY_RST);
            Lockout   <= (nxt == ST_LOCKOUT);
        end
    end

endmodule

// File: tb/tb_pwm_fault_sequencer.sv
// Bench for pwm_fault_sequencer: directed test-plan scenarios plus random
// stimulus, every cycle compared against a window/timestamp reference model.
module tb_pwm_fault_sequencer;

    localparam int FILT = 4, PFC = 20, INV = 10, RW = 50, RP = 4, MAXR = 3;

    logic       clk = 1'b0, rst = 1'b1, start = 1'b0, stop = 1'b0, clr_lock = 1'b0;
    logic [5:0] flags = '1;
    logic       pfc_run, inv1_run, inv2_run, reset_d, lockout;
    logic [2:0] state_code;
    logic [1:0] retry_cnt;
    logic [5:0] fault_src;
    logic [15:0] dut_vec;

    always #10 clk = ~clk;

    pwm_fault_sequencer #(
        .FILT_CYC(FILT), .PFC_SS_CYC(PFC), .INV_DLY_CYC(INV), .RETRY_WAIT_CYC(RW),
        .RST_PULSE_CYC(RP), .MAX_RETRY(MAXR), .TW(20)
    ) dut (
        .CLK_50M(clk), .Rst(rst), .Start(start), .Stop(stop), .Clr_Lock(clr_lock),
        .BusOvp(flags[0]), .IP_Ocp(flags[1]), .InvOcp1(flags[2]), .OP_Ovp1(flags[3]),
        .InvOcp2(flags[4]), .OP_Ovp2(flags[5]),
        .PFC_Run(pfc_run), .INV1_Run(inv1_run), .INV2_Run(inv2_run), .Reset_D(reset_d),
        .Lockout(lockout), .State_Code(state_code), .Retry_Cnt(retry_cnt), .Fault_Src(fault_src)
    );

    assign dut_vec = {pfc_run, inv1_run, inv2_run, reset_d, lockout, state_code, retry_cnt, fault_src};

    int total = 0, bad = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    // Reference model: phase plus entry timestamp, unbounded try count,
    // and each filtered fault as "the raw-sample window is all low".
    int         ph, tries, ent, cyc = 0;
    logic [5:0] src, mf;
    logic [7:0] hist [6];

    task automatic model_reset();
        ph = 0; tries = 0; src = '0; mf = '0; ent = cyc;
        for (int i = 0; i < 6; i++) hist[i] = '1;
    endtask

    task automatic model_step();
        int el, nph;
        bit anyf;
        if (rst) begin
            model_reset();
            return;
        end
        el   = cyc - ent - 1;
        anyf = |mf;
        nph  = ph;
        case (ph)
            0: if (start && !stop && !anyf) nph = 1;
            1, 2, 3: begin
                if (anyf)                          nph = 4;
                else if (stop || !start)           nph = 0;
                else if (ph == 1 && el == PFC - 1) nph = 2;
                else if (ph == 2 && el == INV - 1) nph = 3;
            end
            4: begin
                if (tries > MAXR)      nph = 6;
                else if (stop)         nph = 0;
                else if (el == RW - 1) nph = 5;
            end
            5: if (el == RP - 1) nph = anyf ? 4 : 1;
            6: if (clr_lock && !start) nph = 0;
            default: nph = 0;
        endcase
        if (nph != ph) begin
            ent = cyc;
            if (nph == 0) begin tries = 0; src = '0; end
            if (nph == 4) begin tries++; src = mf; end
        end else if (ph == 3 && el >= RW - 1) begin
            tries = 0;
        end
        ph = nph;
        for (int i = 0; i < 6; i++) begin
            hist[i] = {hist[i][6:0], flags[i]};
            mf[i]   = (hist[i][FILT+1:2] == '0);
        end
    endtask

    function automatic logic [15:0] exp_vec();
        logic [1:0] rc;
        rc = (tries > 3) ? 2'd3 : 2'(tries);
        return {(ph >= 1 && ph <= 3), (ph == 2 || ph == 3), (ph == 3), (ph == 5), (ph == 6),
                3'(ph), rc, src};
    endfunction

    task automatic tick();
        @(posedge clk);
        cyc++;
        model_step();
        @(negedge clk);
        chk("outs", 32'(dut_vec), 32'(exp_vec()));
    endtask

    int n, hi, pulses;
    logic prev_rd;
    int lowc [6];

    initial begin
        model_reset();
        repeat (3) tick();
        chk("reset_state", 32'(dut_vec), 32'h0);
        rst = 1'b0;
        repeat (2) tick();

        // Normal start and stagger
        start = 1'b1;
        tick();
        chk("pfc_cycle1", 32'(pfc_run), 32'd1);
        n = 0;
        while (!inv1_run && n < 100) begin tick(); n++; end
        chk("pfc_to_inv1", 32'(n), 32'(PFC));
        n = 0;
        while (!inv2_run && n < 100) begin tick(); n++; end
        chk("inv1_to_inv2", 32'(n), 32'(INV));
        chk("run_code", 32'(state_code), 32'd3);

        // Glitch rejection, then a real IP_Ocp fault
        flags[1] = 1'b0; repeat (3) tick(); flags[1] = 1'b1;
        repeat (10) tick();
        chk("glitch3_run", 32'(state_code), 32'd3);
        flags[1] = 1'b0; repeat (4) tick(); flags[1] = 1'b1;
        n = 0;
        while (pfc_run && n < 20) begin tick(); n++; end
        chk("fault_latency", 32'(n), 32'd3);
        chk("glitch4_runs", 32'({pfc_run, inv1_run, inv2_run}), 32'd0);
        chk("glitch4_src", 32'(fault_src), 32'b000010);

        // Recover to RUN and let the retry count clear
        n = 0;
        while (state_code != 3'd3 && n < 200) begin tick(); n++; end
        repeat (60) tick();
        chk("retry_clear_pre", 32'(retry_cnt), 32'd0);

        // Successful retry on an InvOcp1 pulse
        flags[2] = 1'b0; repeat (6) tick(); flags[2] = 1'b1;
        n = 0;
        while (pfc_run && n < 20) begin tick(); n++; end
        chk("inv1_src", 32'(fault_src), 32'b000100);
        n = 0;
        while (!reset_d && n < 100) begin tick(); n++; end
        chk("resetd_delay", 32'(n), 32'(RW));
        hi = 1;
        n = 0;
        while (n < 20) begin
            tick(); n++;
            if (reset_d) hi++; else break;
        end
        chk("resetd_width", 32'(hi), 32'(RP));
        chk("retry_to_pfc", 32'(state_code), 32'd1);
        chk("retry_cnt1", 32'(retry_cnt), 32'd1);
        n = 0;
        while (state_code != 3'd3 && n < 60) begin tick(); n++; end
        repeat (RW - 1) tick();
        chk("retry_hold", 32'(retry_cnt), 32'd1);
        tick();
        chk("retry_clr", 32'(retry_cnt), 32'd0);

        // Persistent BusOvp -> lockout
        flags[0] = 1'b0;
        pulses = 0; prev_rd = 1'b0; n = 0;
        while (!lockout && n < 600) begin
            tick(); n++;
            if (reset_d && !prev_rd) pulses++;
            prev_rd = reset_d;
        end
        chk("lock_pulses", 32'(pulses), 32'd3);
        chk("lock_flag", 32'(lockout), 32'd1);
        chk("lock_code", 32'(state_code), 32'd6);
        chk("lock_retry", 32'(retry_cnt), 32'd3);
        chk("lock_src", 32'(fault_src), 32'b000001);
        clr_lock = 1'b1;
        repeat (3) tick();
        chk("clr_with_start", 32'(state_code), 32'd6);
        stop = 1'b1;
        repeat (2) tick();
        chk("stop_ignored", 32'(state_code), 32'd6);
        stop = 1'b0; start = 1'b0;
        tick();
        chk("lock_exit", 32'(state_code), 32'd0);
        chk("idle_clears", 32'({retry_cnt, fault_src}), 32'd0);
        clr_lock = 1'b0; flags[0] = 1'b1;
        repeat (6) tick();

        // Stop and a filtered fault on the same cycle
        start = 1'b1;
        repeat (35) tick();
        chk("run_again", 32'(state_code), 32'd3);
        flags[5] = 1'b0;
        n = 0;
        while (mf == '0 && n < 20) begin tick(); n++; end
        stop = 1'b1;
        tick();
        chk("fault_over_stop", 32'(state_code), 32'd4);
        chk("ovp2_src", 32'(fault_src), 32'b100000);
        tick();
        chk("fault_stop_idle", 32'(state_code), 32'd0);
        stop = 1'b0; flags[5] = 1'b1; start = 1'b0;
        repeat (6) tick();

        // Asynchronous reset during INV1_ON
        start = 1'b1;
        repeat (25) tick();
        chk("inv1_on_code", 32'(state_code), 32'd2);
        rst = 1'b1;
        #1;
        chk("rst_async", 32'(dut_vec), 32'h0);
        model_reset();
        start = 1'b0;
        tick();
        rst = 1'b0;
        repeat (3) tick();
        chk("rst_idle", 32'(state_code), 32'd0);

        // Random traffic against the model
        start = 1'b1;
        for (int i = 0; i < 6; i++) lowc[i] = 0;
        for (int c = 0; c < 2500; c++) begin
            for (int i = 0; i < 6; i++) begin
                if (lowc[i] == 0 && $urandom_range(0, 299) == 0)
                    lowc[i] = ($urandom_range(0, 3) == 0) ? int'($urandom_range(20, 150))
                                                          : int'($urandom_range(1, 8));
                flags[i] = (lowc[i] == 0);
                if (lowc[i] > 0) lowc[i]--;
            end
            if ($urandom_range(0, 249) == 0) start = ~start;
            stop     = ($urandom_range(0, 199) == 0);
            clr_lock = ($urandom_range(0, 29) == 0);
            tick();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, total=%0d bad=%0d", total, bad);
        $fatal(1);
    end

endmodule
